// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake and operand/result bundle for serial_adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester drives operands and start; the adder returns status and result
    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder sharing one full-adder cell over WIDTH cycles
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] s_next;

    // The single full-adder cell working on the current LSBs and the stored carry
    always_comb begin
        fa_s   = a_sr[0] ^ b_sr[0] ^ carry;
        fa_c   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        s_next = {fa_s, s_sr[WIDTH-1:1]};
    end

    // Sequencer: capture operands, shift one bit per cycle, publish the result once complete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    s_sr  <= s_next;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    // Result registers only move here, so partial sums are never visible
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum_q  <= s_next;
                        cout_q <= fa_c;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status is decoded straight from the state register
    always_comb begin
        bus.busy = (state == S_SHIFT);
        bus.done = (state == S_DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder against an arithmetic reference
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One start pulse; checks busy length, done timing, result and result hold during SHIFT
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input string tag);
        logic [W:0]   exp_full;
        logic [W-1:0] held_sum;
        logic         held_cout;
        int           busy_cnt;
        int           done_k;
        int           done_cnt;
        int           hold_bad;
        exp_full = ref_add(xa, xb);
        @(negedge clk);
        bus.a = xa;
        bus.b = xb;
        bus.start = 1'b1;
        held_sum  = bus.sum;
        held_cout = bus.cout;
        busy_cnt = 0;
        done_k   = 0;
        done_cnt = 0;
        hold_bad = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.a = W'($urandom);
                bus.b = W'($urandom);
            end
            if (bus.busy) begin
                busy_cnt++;
                if (bus.sum !== held_sum || bus.cout !== held_cout) hold_bad++;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_k == 0) begin
                    done_k = k;
                    check({tag, "_sum"}, 32'(bus.sum), 32'(exp_full[W-1:0]));
                    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_full[W]));
                end
            end
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
        check({tag, "_done_at"}, 32'(done_k), 32'(W + 1));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_hold_in_shift"}, 32'(hold_bad), 32'd0);
        check({tag, "_sum_after"}, 32'(bus.sum), 32'(exp_full[W-1:0]));
    endtask

    initial begin
        int done_cnt;
        int first_k;
        int second_k;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;

        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_sum",  32'(bus.sum),  32'd0);
        check("reset_cout", 32'(bus.cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(8'd3, 8'd5, "a3_b5");
        do_op(8'd200, 8'd100, "a200_b100");
        do_op(8'd255, 8'd255, "a255_b255");
        do_op(8'd0, 8'd0, "a0_b0");

        // Restart attempt and operand change in mid-operation must be ignored
        @(negedge clk);
        bus.a = 8'd10;
        bus.b = 8'd20;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        done_cnt = 0;
        first_k  = 0;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) begin
                bus.a = 8'd255;
                bus.b = 8'd255;
                bus.start = 1'b1;
            end
            if (k == 4) bus.start = 1'b0;
            if (bus.done) begin
                done_cnt++;
                if (first_k == 0) begin
                    first_k = k;
                    check("restart_sum",  32'(bus.sum),  32'd30);
                    check("restart_cout", 32'(bus.cout), 32'd0);
                end
            end
        end
        check("restart_done_count", 32'(done_cnt), 32'd1);
        check("restart_done_at", 32'(first_k), 32'(W + 1));

        // Asynchronous reset in the middle of SHIFT
        @(negedge clk);
        bus.a = 8'd100;
        bus.b = 8'd100;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum",  32'(bus.sum),  32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_cnt++;
        end
        check("abort_idle_activity", 32'(done_cnt), 32'd0);
        do_op(8'd1, 8'd1, "a1_b1");

        // start held high: back-to-back operations
        @(negedge clk);
        bus.a = 8'd7;
        bus.b = 8'd9;
        bus.start = 1'b1;
        first_k  = 0;
        second_k = 0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 2) begin
                bus.a = 8'd128;
                bus.b = 8'd128;
            end
            if (bus.done) begin
                if (first_k == 0) begin
                    first_k = k;
                    check("b2b_first_sum",  32'(bus.sum),  32'd16);
                    check("b2b_first_cout", 32'(bus.cout), 32'd0);
                end else if (second_k == 0) begin
                    second_k = k;
                    bus.start = 1'b0;
                    check("b2b_second_sum",  32'(bus.sum),  32'd0);
                    check("b2b_second_cout", 32'(bus.cout), 32'd1);
                end
            end
        end
        bus.start = 1'b0;
        check("b2b_first_at", 32'(first_k), 32'(W + 1));
        check("b2b_spacing", 32'(second_k - first_k), 32'(W + 2));

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first adder: the additive counterpart to the team's subtractor blocks.
- Reuses one full-adder cell and one carry flip-flop over WIDTH clock cycles.
- Internal operand shift registers, a bit counter and a 3-state FSM with a start/busy/done handshake.
- Sits beside the combinational subtractor library; its results cross-check subtractor outputs, since (a-b)+b must equal a.

Parameters:
- WIDTH, 8, operand and sum width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request an addition; sampled only in IDLE
- a  input  WIDTH  augend; captured on the accepted start edge
- b  input  WIDTH  addend; captured on the accepted start edge
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  one-cycle pulse: sum/cout valid
- sum  output  WIDTH  registered result, holds until next completion
- cout  output  1  registered carry-out of the MSB, holds with sum

Behaviour:
- One clock; reset is asynchronous and active-low.
- rst_n low, immediately and independent of clk:
  - FSM=IDLE; busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flip-flop and counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: load a_sr<=a, b_sr<=b, carry<=0, cnt<=0, go SHIFT.
  - start=0: stay.
- SHIFT (busy=1), each edge:
  - Form the full-adder bit: s = a_sr[0]^b_sr[0]^carry, c = majority(a_sr[0],b_sr[0],carry).
  - Shift s_sr right, inserting s at bit WIDTH-1.
  - Shift a_sr and b_sr right, filling 0.
  - carry<=c, cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: sum<=final shifted s_sr value, cout<=c, go DONE.
- DONE: done=1, busy=0 for exactly one cycle, then unconditionally IDLE. start is ignored in DONE.
- Latency: start accepted at edge E0; done high during the cycle after edge E0+WIDTH; WIDTH+2 cycles from start to start.
- Operand isolation:
  - start is ignored while busy or done; a/b changes after capture have no effect on the result.
  - sum/cout never show partial values. They change only on the completing edge (or reset) and hold through IDLE and subsequent SHIFT.
- Arithmetic: unsigned modulo 2^WIDTH; {cout,sum} = a+b exactly (WIDTH+1 bits).
- Counter width is clog2(WIDTH); no wrap beyond WIDTH-1 occurs.
- Reset mid-SHIFT: the operation is aborted and all outputs zero. After release, the block waits in IDLE for a new start.
- start held continuously high: back-to-back operations, one every WIDTH+2 cycles, each using a/b sampled at its accepting edge.

Test Plan:
- WIDTH=8, a=3, b=5, start pulse:
  - busy=1 for 8 cycles.
  - Then done pulse with sum=8, cout=0.
  - sum stays 8 afterwards.
- a=200, b=100 -> sum=44, cout=1; done exactly 9 edges after the start edge.
- a=255, b=255 -> sum=254, cout=1. Then a=0, b=0 -> sum=0, cout=0 (carry flip-flop correctly cleared).
- Start a=10, b=20; mid-operation change a=b=255 and pulse start again:
  - second start ignored; result sum=30, cout=0.
  - only one done pulse.
- Assert rst_n low at SHIFT cycle 4 of a=100, b=100:
  - busy, done, sum, cout go 0 asynchronously.
  - After release, no done until a new start; new a=1, b=1 -> sum=2.
- Hold start=1 with a=7, b=9 then a=128, b=128:
  - consecutive done pulses 10 cycles apart.
  - Results: sum=16, cout=0; then sum=0, cout=1.
